sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO.
//  - Successor to the fixed 8x8 FIFO controller.
//  - Generalised in data width and depth.
//  - Adds: registered read with a valid strobe, programmable almost-full and
//    almost-empty flags, sticky overflow/underflow error flags, and a write
//    accepted on a full FIFO when a read happens in the same cycle.
//  - Buffers byte or word streams between producer/consumer logic in the labs.
// PARAMETERS
//  DATA_W     8   data width in bits, >=1
//  DEPTH      8   number of entries; power of 2, >=2
//  ADDR_W     $clog2(DEPTH)  pointer width (derived, do not override)
//  AFULL_TH   6   almost_full asserted when count >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH  2   almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         asynchronous, active-low reset
//  wr_en         in   1         write request
//  din           in   DATA_W    write data, sampled when a write is accepted
//  rd_en         in   1         read request
//  dout          out  DATA_W    read data, registered
//  dout_valid    out  1         1-cycle pulse: dout updated this cycle
//  full          out  1         count == DEPTH
//  empty         out  1         count == 0
//  almost_full   out  1         count >= AFULL_TH
//  almost_empty  out  1         count <= AEMPTY_TH
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  overflow      out  1         sticky: a write was rejected
//  underflow     out  1         sticky: a read was rejected
//  clr_err       in   1         synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous, may occur mid-operation):
//    - wr_ptr, rd_ptr, count, dout, dout_valid, overflow, underflow all go to 0.
//    - Hence empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0 ? 1 : 0).
//    - Memory contents are not reset.
//    - Outputs are valid in the cycle reset is asserted.
//  - Storage: DEPTH x DATA_W register array, written on the rising edge of clk.
//  - Definitions (all evaluated on pre-edge state):
//    - rd_acc = rd_en & ~empty
//    - wr_acc = wr_en & (~full | rd_acc)
//  - Write accepted (wr_acc):
//    - mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1.
//    - Pointer wraps modulo DEPTH (natural ADDR_W rollover).
//  - Read accepted (rd_acc):
//    - dout <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (wraps); dout_valid <= 1.
//    - Otherwise dout_valid <= 0 and dout holds its last value.
//    - Read latency is 1 cycle: data appears the cycle after rd_en is sampled.
//  - Occupancy update:
//    - count <= count + wr_acc - rd_acc.
//    - Both accepted: count unchanged.
//  - Full + wr_en + rd_en: both accepted.
//    - dout receives the oldest entry; din overwrites its slot after the read.
//    - count stays at DEPTH; no overflow.
//  - Empty + wr_en + rd_en:
//    - Write accepted, read rejected; underflow set.
//    - No same-cycle bypass: data becomes readable the following cycle.
//  - Flags full, empty, almost_full, almost_empty are combinational from count.
//  - Error flags:
//    - overflow <= 1 when wr_en & ~wr_acc.
//    - underflow <= 1 when rd_en & ~rd_acc.
//    - Both remain set until clr_err=1 or reset.
//    - clr_err in the same cycle as a new error: error wins (flag stays 1).
//  - Rejected operations change no pointer, count or memory.
// TESTING
//  1. Reset with DEPTH=8: count=0, empty=1, almost_empty=1, dout=0,
//     overflow=0, underflow=0.
//  2. Write 0x01..0x08 -> full=1, count=8, almost_full set once count=6.
//     Then read 8x -> dout 0x01..0x08, each 1 cycle after rd_en,
//     dout_valid pulsing; finally empty=1.
//  3. Full, write 0xAA with rd_en=0 -> overflow=1, count=8, contents unchanged.
//     Then pulse clr_err -> overflow=0.
//  4. Full, wr_en=rd_en=1 with din=0x55 -> dout=0x01, count stays 8.
//     Drain -> 0x02..0x08 then 0x55.
//  5. Empty, wr_en=rd_en=1 with din=0x33 -> count=1, underflow=1,
//     dout_valid=0. Next-cycle read -> dout=0x33.
//  6. Wrap and reset: stream 20 words 0x10..0x23 with interleaved reads,
//     checking order across pointer wrap. Then assert rst_n=0 with count=5 ->
//     count=0 and empty=1 immediately. With DATA_W=16, DEPTH=16: repeat test 2.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with a registered read port, almost flags,
// sticky error flags, and write-through-on-full when a read frees a slot.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              ovf_ev;
    logic              udf_ev;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // A read on a full FIFO frees the slot the write then reuses.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    assign ovf_ev = wr_en & ~wr_acc;
    assign udf_ev = rd_en & ~rd_acc;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_acc;
            if (rd_acc) begin
                dout <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_ev) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_ev) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference model plus directed checks,
// on an 8x8 instance and a 16x16 instance.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    logic        wr16;
    logic [15:0] din16;
    logic        rd16;
    logic        clr16;
    logic [15:0] dout16;
    logic        valid16;
    logic        full16;
    logic        empty16;
    logic        af16;
    logic        ae16;
    logic [4:0]  count16;
    logic        ovf16;
    logic        udf16;

    int tests;
    int fails;

    byte unsigned q[$];
    logic [7:0]   m_dout;
    logic         m_valid;
    logic         m_ovf;
    logic         m_udf;
    logic         m_wok;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(
        .DATA_W(16), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(3)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr16), .din(din16),
        .rd_en(rd16), .dout(dout16), .dout_valid(valid16),
        .full(full16), .empty(empty16), .almost_full(af16),
        .almost_empty(ae16), .count(count16),
        .overflow(ovf16), .underflow(udf16), .clr_err(clr16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 6));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ".valid"}, 32'(dout_valid), 32'(m_valid));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // One clock cycle: drive, predict from queue occupancy, then check.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        logic rok;
        wr_en   = w;
        din     = d;
        rd_en   = r;
        clr_err = c;
        rok     = r && (q.size() > 0);
        m_wok   = w && ((q.size() < 8) || rok);
        m_valid = rok;
        if (rok) m_dout = q.pop_front();
        if (m_wok) q.push_back(d);
        if (w && !m_wok) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (r && !rok) m_udf = 1'b1;
        else if (c) m_udf = 1'b0;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int sent;
        int next_exp;
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        din     = 8'h00;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr16    = 1'b0;
        din16   = 16'h0;
        rd16    = 1'b0;
        clr16   = 1'b0;
        model_reset();

        #3;
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.aempty", 32'(almost_empty), 1);
        chk("rst.afull", 32'(almost_full), 0);
        chk("rst.dout", 32'(dout), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.udf", 32'(underflow), 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 8; i++) begin
            step("t2.wr", 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 5) chk("t2.af_at5", 32'(almost_full), 0);
            if (i == 6) chk("t2.af_at6", 32'(almost_full), 1);
        end
        chk("t2.full", 32'(full), 1);
        chk("t2.count8", 32'(count), 8);
        for (int i = 1; i <= 8; i++) begin
            step("t2.rd", 1'b0, 8'h00, 1'b1, 1'b0);
            chk("t2.dout", 32'(dout), 32'(i));
            chk("t2.pulse", 32'(dout_valid), 1);
        end
        step("t2.idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2.vlow", 32'(dout_valid), 0);
        chk("t2.empty", 32'(empty), 1);

        for (int i = 1; i <= 8; i++) begin
            step("t3.fill", 1'b1, 8'(i), 1'b0, 1'b0);
        end
        step("t3.ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("t3.ovf_set", 32'(overflow), 1);
        chk("t3.cnt", 32'(count), 8);
        step("t3.clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3.ovf_clr", 32'(overflow), 0);

        step("t4.both", 1'b1, 8'h55, 1'b1, 1'b0);
        chk("t4.dout01", 32'(dout), 32'h01);
        chk("t4.cnt8", 32'(count), 8);
        chk("t4.noovf", 32'(overflow), 0);
        for (int i = 2; i <= 9; i++) begin
            step("t4.drain", 1'b0, 8'h00, 1'b1, 1'b0);
            chk("t4.order", 32'(dout), (i == 9) ? 32'h55 : 32'(i));
        end

        step("t5.both", 1'b1, 8'h33, 1'b1, 1'b0);
        chk("t5.cnt1", 32'(count), 1);
        chk("t5.udf", 32'(underflow), 1);
        chk("t5.nvalid", 32'(dout_valid), 0);
        step("t5.rd", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5.dout33", 32'(dout), 32'h33);
        step("t5.clr_err_wins", 1'b0, 8'h00, 1'b1, 1'b1);
        chk("t5.udf_kept", 32'(underflow), 1);
        step("t5.clr", 1'b0, 8'h00, 1'b0, 1'b1);

        sent     = 0;
        next_exp = 8'h10;
        for (int k = 0; k < 400 && (sent < 20 || q.size() > 0); k++) begin
            logic w;
            logic r;
            w = (sent < 20) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            step("t6.stream", w, 8'(8'h10 + sent), r, 1'b0);
            if (m_wok) sent++;
            if (m_valid) begin
                chk("t6.order", 32'(dout), 32'(next_exp));
                next_exp++;
            end
        end
        chk("t6.all_read", 32'(next_exp), 32'h24);

        for (int i = 0; i < 5; i++) begin
            step("t6.fill5", 1'b1, 8'($urandom), 1'b0, 1'b0);
        end
        chk("t6.cnt5", 32'(count), 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6.rst_cnt", 32'(count), 0);
        chk("t6.rst_empty", 32'(empty), 1);
        check_all("t6.rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("t6.post_rst");

        for (int k = 0; k < 300; k++) begin
            step("rand", 1'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        for (int i = 1; i <= 16; i++) begin
            wr16  = 1'b1;
            din16 = 16'(i * 16'h0101);
            @(posedge clk);
            #1;
            if (i == 11) chk("w16.af11", 32'(af16), 0);
            if (i == 12) chk("w16.af12", 32'(af16), 1);
        end
        wr16 = 1'b0;
        chk("w16.full", 32'(full16), 1);
        chk("w16.count", 32'(count16), 16);
        for (int i = 1; i <= 16; i++) begin
            rd16 = 1'b1;
            @(posedge clk);
            #1;
            chk("w16.dout", 32'(dout16), 32'(i * 16'h0101));
            chk("w16.valid", 32'(valid16), 1);
        end
        rd16 = 1'b0;
        @(posedge clk);
        #1;
        chk("w16.empty", 32'(empty16), 1);
        chk("w16.vlow", 32'(valid16), 0);
        chk("w16.noerr", 32'({ovf16, udf16}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
